mm_scheduler: RTL and testbench

MM_SCHEDULER -- requirements
Module: mm_scheduler

---
 rtl/mm_scheduler.sv | 166 ++++++++++++++++
 tb/tb_mm_scheduler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_scheduler.sv
// Two-requester front end for a matrix-multiply core: round-robin job grant,
// operand forwarding, result routing. Optional watchdog under MM_SCHED_TIMEOUT_EN.
module mm_scheduler #(
  parameter int DATA_W = 8,
  parameter int RES_W  = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req,
  output logic [1:0]              gnt,
  input  logic [DATA_W-1:0]       in_data0,
  input  logic [DATA_W-1:0]       in_data1,
  input  logic [1:0]              col_end,
  input  logic [1:0]              row_end,
  output logic [DATA_W-1:0]       mm_in_data,
  output logic                    mm_col_end,
  output logic                    mm_row_end,
  input  logic                    mm_busy,
  input  logic                    mm_valid,
  input  logic                    mm_is_legal,
  input  logic signed [RES_W-1:0] mm_out_data,
  output logic [1:0]              res_valid,
  output logic signed [RES_W-1:0] res_data,
  output logic                    res_illegal,
  output logic [1:0]              done,
  output logic                    owner,
  output logic                    timeout_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    WAIT   = 3'd3,
    RUN    = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t state, state_nxt;
  logic   last_served;
  logic   win;
  logic   own_row_end;
  logic   load_act;
  logic   res_act;
  logic   wd_expire;

  logic [DATA_W-1:0]       mm_data_p1;
  logic                    mm_col_p1;
  logic                    mm_row_p1;
  logic [1:0]              res_vld_p1;
  logic signed [RES_W-1:0] res_data_p1;
  logic                    res_ill_p1;

  function automatic logic [1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  // A lone request wins outright; a tie goes to whoever was not served last.
  function automatic logic pick(input logic [1:0] r, input logic last);
    case (r)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      default: pick = ~last;
    endcase
  endfunction

  assign win         = pick(req, last_served);
  assign own_row_end = row_end[owner];
  assign load_act    = (state == LOAD_A) || (state == LOAD_B);
  assign res_act     = mm_valid && ((state == WAIT) || (state == RUN));

`ifdef MM_SCHED_TIMEOUT_EN
  logic [9:0] wdog;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog <= '0;
    end else if ((state == LOAD_B) && (state_nxt == WAIT)) begin
      wdog <= '0;
    end else if ((state == WAIT) || (state == RUN)) begin
      wdog <= wdog + 10'd1;
    end
  end

  assign wd_expire   = ((state == WAIT) || (state == RUN)) && (wdog == 10'h3FF);
  assign timeout_err = wd_expire;
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = LOAD_A;
      LOAD_A:  if (own_row_end) state_nxt = LOAD_B;
      LOAD_B:  if (own_row_end) state_nxt = WAIT;
      WAIT: begin
        if (wd_expire)    state_nxt = DONE;
        else if (mm_busy) state_nxt = RUN;
      end
      RUN:     if (wd_expire || !mm_busy) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      gnt         <= 2'b00;
      owner       <= 1'b0;
      last_served <= 1'b1;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && (|req)) begin
        owner <= win;
        gnt   <= onehot(win);
      end
      if (((state == WAIT) || (state == RUN)) && (state_nxt == DONE)) begin
        gnt <= 2'b00;
      end
      if (state == DONE) begin
        last_served <= owner;
      end
    end
  end

  assign done = (state == DONE) ? onehot(owner) : 2'b00;

  // Stage p1: owner operand stream forwarded to the core
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mm_data_p1 <= '0;
      mm_col_p1  <= 1'b0;
      mm_row_p1  <= 1'b0;
    end else begin
      mm_data_p1 <= load_act ? (owner ? in_data1 : in_data0) : '0;
      mm_col_p1  <= load_act & col_end[owner];
      mm_row_p1  <= load_act & row_end[owner];
    end
  end

  // Stage p1: core result routed back to the job owner
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_vld_p1  <= 2'b00;
      res_data_p1 <= '0;
      res_ill_p1  <= 1'b0;
    end else begin
      res_vld_p1 <= res_act ? onehot(owner) : 2'b00;
      res_ill_p1 <= res_act & ~mm_is_legal;
      if (res_act) begin
        res_data_p1 <= mm_out_data;
      end
    end
  end

  assign mm_in_data  = mm_data_p1;
  assign mm_col_end  = mm_col_p1;
  assign mm_row_end  = mm_row_p1;
  assign res_valid   = res_vld_p1;
  assign res_data    = res_data_p1;
  assign res_illegal = res_ill_p1;

endmodule

// File: tb/tb_mm_scheduler.sv
// Randomised job-level bench for mm_scheduler against a transaction model.
module tb_mm_scheduler;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req;
  logic [1:0]        gnt;
  logic [7:0]        in_data0, in_data1;
  logic [1:0]        col_end, row_end;
  logic [7:0]        mm_in_data;
  logic              mm_col_end, mm_row_end;
  logic              mm_busy, mm_valid, mm_is_legal;
  logic signed [11:0] mm_out_data;
  logic [1:0]        res_valid;
  logic signed [11:0] res_data;
  logic              res_illegal;
  logic [1:0]        done;
  logic              owner;
  logic              timeout_err;

  mm_scheduler dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .in_data0(in_data0), .in_data1(in_data1),
    .col_end(col_end), .row_end(row_end),
    .mm_in_data(mm_in_data), .mm_col_end(mm_col_end), .mm_row_end(mm_row_end),
    .mm_busy(mm_busy), .mm_valid(mm_valid), .mm_is_legal(mm_is_legal),
    .mm_out_data(mm_out_data),
    .res_valid(res_valid), .res_data(res_data), .res_illegal(res_illegal),
    .done(done), .owner(owner), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model of the observable outputs after the next clock edge
  logic       last_srv;
  logic [1:0] e_gnt;
  logic       e_owner;
  logic [7:0] e_mm_d;
  logic       e_mm_c, e_mm_r;
  logic [1:0] e_rv;
  logic [11:0] e_rd;
  logic       e_ri;
  logic [1:0] e_done;
  bit         trail_ok;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] oh(input logic b);
    return b ? 2'b10 : 2'b01;
  endfunction

  task automatic model_reset();
    last_srv = 1'b1;
    e_gnt = 2'b00; e_owner = 1'b0;
    e_mm_d = 8'h00; e_mm_c = 1'b0; e_mm_r = 1'b0;
    e_rv = 2'b00; e_rd = 12'h000; e_ri = 1'b0; e_done = 2'b00;
    trail_ok = 1'b0;
  endtask

  task automatic compare_all();
    logic [9:0] mm_obs, mm_exp;
    mm_obs = {mm_in_data, mm_col_end, mm_row_end};
    mm_exp = {e_mm_d, e_mm_c, e_mm_r};
    // the cycle right after the last operand may show either the trailing byte or zeros
    if (trail_ok && mm_obs == 10'd0) mm_exp = 10'd0;
    trail_ok = 1'b0;
    check_val("gnt", {30'd0, gnt}, {30'd0, e_gnt});
    check_val("owner", {31'd0, owner}, {31'd0, e_owner});
    check_val("mm_stream", {22'd0, mm_obs}, {22'd0, mm_exp});
    check_val("res_valid", {30'd0, res_valid}, {30'd0, e_rv});
    check_val("res_data", {20'd0, res_data}, {20'd0, e_rd});
    check_val("res_illegal", {31'd0, res_illegal}, {31'd0, e_ri});
    check_val("done", {30'd0, done}, {30'd0, e_done});
    check_val("timeout_err", {31'd0, timeout_err}, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic rand_inputs();
    req         = 2'($urandom);
    in_data0    = 8'($urandom);
    in_data1    = 8'($urandom);
    col_end     = 2'($urandom);
    row_end     = 2'($urandom);
    mm_busy     = 1'($urandom);
    mm_valid    = 1'($urandom);
    mm_is_legal = 1'($urandom);
    mm_out_data = 12'($urandom);
  endtask

  task automatic set_owner(input logic w, input logic [7:0] d, input logic c, input logic r);
    if (w) in_data1 = d; else in_data0 = d;
    col_end[w] = c;
    row_end[w] = r;
    e_mm_d = d; e_mm_c = c; e_mm_r = r;
  endtask

  // core result strobe during WAIT/RUN; the model expects it one cycle later
  task automatic drive_res(input logic w, input logic v, input logic [11:0] d, input logic legal);
    mm_valid = v; mm_out_data = d; mm_is_legal = legal;
    e_rv = v ? oh(w) : 2'b00;
    e_ri = v & ~legal;
    if (v) e_rd = d;
  endtask

  task automatic drive_res_rand(input logic w);
    drive_res(w, 1'($urandom), 12'($urandom), 1'($urandom));
  endtask

  // mode: 0 random job, 1 directed bytes 1..N plus forced results, 2 watchdog, 3 abort in RUN
  task automatic run_job(input logic [1:0] r, input int mode);
    logic w;
    int   na, nb, nw, nr, n;
    bit   dir;
    dir = (mode == 1);
    w = (r == 2'b01) ? 1'b0 : (r == 2'b10) ? 1'b1 : ~last_srv;

    rand_inputs();
    req = r;
    e_gnt = oh(w); e_owner = w;
    e_mm_d = 8'h00; e_mm_c = 1'b0; e_mm_r = 1'b0;
    e_rv = 2'b00; e_ri = 1'b0; e_done = 2'b00;
    tick();

    na = dir ? 4 : $urandom_range(1, 5);
    nb = dir ? 4 : $urandom_range(1, 5);
    for (int m = 0; m < 2; m++) begin
      n = (m == 0) ? na : nb;
      for (int k = 0; k < n; k++) begin
        if (!dir && $urandom_range(0, 3) == 0) begin
          rand_inputs();
          set_owner(w, 8'($urandom), 1'($urandom), 1'b0);
          e_rv = 2'b00; e_ri = 1'b0;
          tick();
        end
        rand_inputs();
        set_owner(w, dir ? 8'(m * 4 + k + 1) : 8'($urandom),
                  dir ? (k % 2 == 1) : 1'($urandom), (k == n - 1));
        if (m == 1 && k == n - 1) trail_ok = 1'b1;
        e_rv = 2'b00; e_ri = 1'b0;
        tick();
      end
    end
    e_mm_d = 8'h00; e_mm_c = 1'b0; e_mm_r = 1'b0;

    if (mode == 2) begin
      int hit;
      hit = 0;
      e_rv = 2'b00; e_ri = 1'b0;
      for (int k = 1; k <= 1100 && hit == 0; k++) begin
        rand_inputs();
        mm_busy = 1'b0; mm_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (timeout_err) hit = k;
      end
      check_val("timeout_cycle", hit, 1023);
      rand_inputs();
      mm_valid = 1'b0;
      e_gnt = 2'b00; e_done = oh(w);
      tick();
    end else begin
      nw = dir ? 1 : $urandom_range(0, 3);
      for (int k = 0; k < nw; k++) begin
        rand_inputs();
        mm_busy = 1'b0;
        if (dir) drive_res(w, 1'b1, 12'($urandom), 1'b0);
        else drive_res_rand(w);
        tick();
      end
      rand_inputs();
      mm_busy = 1'b1;
      drive_res_rand(w);
      tick();

      if (mode == 3) begin
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        req = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        return;
      end

      nr = dir ? 1 : $urandom_range(0, 4);
      for (int k = 0; k < nr; k++) begin
        rand_inputs();
        mm_busy = 1'b1;
        if (dir) drive_res(w, 1'b1, 12'hFFB, 1'b1);
        else drive_res_rand(w);
        tick();
      end
      rand_inputs();
      mm_busy = 1'b0;
      drive_res_rand(w);
      e_gnt = 2'b00; e_done = oh(w);
      tick();
    end

    rand_inputs();
    e_rv = 2'b00; e_ri = 1'b0; e_done = 2'b00;
    last_srv = w;
    tick();
  endtask

  task automatic idle_cycle();
    rand_inputs();
    req = 2'b00;
    e_rv = 2'b00; e_ri = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    rand_inputs();
    req = 2'b00;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    idle_cycle();

    run_job(2'b11, 0);
    run_job(2'b11, 0);
    run_job(2'b11, 0);
    run_job(2'b01, 1);
    idle_cycle();
    run_job(2'b10, 1);

    for (int j = 0; j < 20; j++) begin
      if ($urandom_range(0, 2) == 0) idle_cycle();
      run_job(2'($urandom_range(1, 3)), 0);
    end

    run_job(2'($urandom_range(1, 3)), 3);
    idle_cycle();
    run_job(2'b11, 0);

`ifdef MM_SCHED_TIMEOUT_EN
    run_job(2'b10, 2);
    idle_cycle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
